uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter: the transmit-side counterpart of the team's UART receiver and its timer. It accepts one parallel character per valid/ready handshake and shifts it out as an asynchronous serial frame: start bit, data LSB-first, optional parity, one stop bit. Character length and bit period are run-time configurable with the same encoding the receive path uses, so a TX/RX pair shares one configuration register set.

## Interface
Parameters:
- none. Widths are fixed to match the receive path.

Ports:
- `clk`  input  1  system clock.
- `n_rst`  input  1  reset, asynchronous, active-low.
- `data_size`  input  4  data bits per frame, valid 5..8; sampled at handshake.
- `bit_period`  input  14  clock cycles per serial bit; sampled at handshake.
- `tx_data`  input  8  character to send; bits above `data_size` ignored.
- `tx_valid`  input  1  character available.
- `tx_ready`  output  1  transmitter can accept a character.
- `serial_out`  output  1  serial line, idle high.
- `tx_busy`  output  1  frame in progress.
- `frame_done`  output  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Handshake: a transfer occurs on a rising edge where `tx_valid && tx_ready`. On that edge:
  - latch `tx_data` into a shift register;
  - latch `data_size`, clamped so 0..4 becomes 5 and 9..15 becomes 8;
  - latch `bit_period`, with 0 treated as 1;
  - go to START.
- START: drive `serial_out` = 0 for one bit period, then go to DATA.
- DATA: drive shift-register bit 0, shift right each bit period, count bits. After the latched `data_size` bits, go to PARITY if enabled, else STOP.
- STOP: drive `serial_out` = 1 for one bit period, then go to IDLE.
- Bit timing: a period counter counts 1..`bit_period`. Its rollover advances to the next bit. The counter clears on every state change.
- `tx_ready` = (state == IDLE). `tx_busy` = !`tx_ready`.
- `tx_valid` and `tx_data` are ignored while busy. Input changes mid-frame have no effect, because all frame parameters are latched.
- `serial_out`, `frame_done` and the state are registered, so no combinational glitches appear on the line.

## Timing
- Reset values:
  - `serial_out` = 1, `tx_ready` = 1, `tx_busy` = 0, `frame_done` = 0;
  - state IDLE, all counters 0.
- Handshake on edge E0: `serial_out` falls at E0 and the start bit lasts exactly `bit_period` cycles.
- Each bit is held for exactly `bit_period` cycles (the latched, clamped value).
- Frame length: (2 + `data_size`) × `bit_period` cycles, plus `bit_period` if parity is enabled.
- End of frame:
  - the edge ending the stop bit returns the FSM to IDLE;
  - `frame_done` is high for the following single cycle;
  - `tx_ready` is high in that same cycle.
- Back-to-back frames: a handshake in the `frame_done` cycle starts the next start bit on the following edge. Back-to-back frames have zero idle gap.
- Reset mid-frame: `serial_out` goes to 1 immediately (asynchronous). The frame is abandoned and no `frame_done` is produced.
- `bit_period` = 1: every bit lasts one cycle. The period counter rolls over every cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - the PARITY state is compiled in;
  - after the data bits, one even-parity bit (XOR of the transmitted data bits) is sent for one bit period before STOP.
- Undefined:
  - no PARITY state and no parity logic;
  - frame is start + data + stop.
- The port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_state_t`;
  - constants `UART_MIN_DATA_BITS` = 5 and `UART_MAX_DATA_BITS` = 8;
  - the widths 4 (size) and 14 (period), which the receive side also imports.
- Sub-module: the existing `flex_counter`, instantiated twice:
  - 14-bit bit-period counter;
  - 4-bit data-bit counter.
- FSM, shift register, and parity accumulator live in `uart_tx`.

## Test plan
- Basic frame: `data_size`=8, `bit_period`=10, handshake 0xA5.
  - `serial_out` sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles.
  - `frame_done` pulses 100 cycles after the handshake.
- Short character: `data_size`=5, `bit_period`=4, data 0xFF.
  - Line shows 0, then five 1s, then stop 1.
  - Frame is 28 cycles; bits 5..7 are never sent.
- Back-to-back: hold `tx_valid` high with 0x00 then 0xFF.
  - Second start bit begins the cycle after the first `frame_done`, with no idle gap.
  - `tx_ready` is high for exactly one cycle between frames.
- Busy and clamp: change `tx_data`, `data_size` and `bit_period` mid-frame, and pulse `tx_valid`.
  - The frame is unaffected and no second frame is accepted.
  - Separately, `data_size`=12 sends 8 bits and `bit_period`=0 sends 1-cycle bits.
- Reset mid-data: assert `n_rst` low during bit 3.
  - `serial_out`=1 and `tx_ready`=1 immediately, with no `frame_done`.
  - After release, a fresh 0x3C frame is correct.
- Parity (macro defined): `data_size`=7, data 0x07.
  - Parity bit = 1, frame is 10 bit periods.
  - Data 0x03 gives parity 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: field widths, data-size limits and the transmitter state type.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_SIZE_W        = 4;
  localparam int UART_PERIOD_W      = 14;
  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  // Out-of-range character lengths snap to the nearest supported size.
  function automatic logic [UART_SIZE_W-1:0] clamp_data_size(input logic [UART_SIZE_W-1:0] size);
    if (size < UART_SIZE_W'(UART_MIN_DATA_BITS)) return UART_SIZE_W'(UART_MIN_DATA_BITS);
    if (size > UART_SIZE_W'(UART_MAX_DATA_BITS)) return UART_SIZE_W'(UART_MAX_DATA_BITS);
    return size;
  endfunction

  function automatic logic [UART_PERIOD_W-1:0] clamp_bit_period(input logic [UART_PERIOD_W-1:0] period);
    return (period == '0) ? UART_PERIOD_W'(1) : period;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter: counts enabled cycles and flags the cycle that completes rollover_val counts.
// rollover_flag is combinational so the owner can act on the same edge the count wraps.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;

  // rollover_val is never 0 here: the owner clamps it to at least 1.
  assign rollover_flag = count_enable && (count == rollover_val - WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= rollover_flag ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit before STOP.
module uart_tx
  import uart_pkg::*;
(
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [UART_SIZE_W-1:0]   data_size,
  input  logic [UART_PERIOD_W-1:0] bit_period,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     serial_out,
  output logic                     tx_busy,
  output logic                     frame_done
);

  tx_state_t                state, next_state;
  logic [7:0]               shift_q, shift_d;
  logic [UART_SIZE_W-1:0]   size_q;
  logic [UART_PERIOD_W-1:0] period_q;
  logic                     serial_d;
  logic                     handshake;
  logic                     state_change;
  logic                     bit_tick;
  logic                     last_bit;
  logic                     data_tick;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  assign tx_ready     = (state == IDLE);
  assign tx_busy      = ~tx_ready;
  assign handshake    = tx_valid && tx_ready;
  assign state_change = (next_state != state);
  assign data_tick    = (state == DATA) && bit_tick;

  flex_counter #(.WIDTH(UART_PERIOD_W)) u_period_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_change),
    .count_enable  (state != IDLE),
    .rollover_val  (period_q),
    .rollover_flag (bit_tick)
  );

  flex_counter #(.WIDTH(UART_SIZE_W)) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_change),
    .count_enable  (data_tick),
    .rollover_val  (size_q),
    .rollover_flag (last_bit)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (handshake) next_state = START;
      START:  if (bit_tick)  next_state = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (last_bit)  next_state = PARITY;
      PARITY: if (bit_tick)  next_state = STOP;
`else
      DATA:   if (last_bit)  next_state = STOP;
`endif
      STOP:   if (bit_tick)  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    if (handshake)      shift_d = tx_data;
    else if (data_tick) shift_d = shift_q >> 1;
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (handshake)      parity_d = 1'b0;
    else if (data_tick) parity_d = parity_q ^ shift_q[0];
  end
`endif

  // The line level is decoded from the upcoming state and registered, so it changes on the edge cleanly.
  always_comb begin
    serial_d = 1'b1;
    case (next_state)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      size_q     <= UART_SIZE_W'(UART_MAX_DATA_BITS);
      period_q   <= UART_PERIOD_W'(1);
      serial_out <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      shift_q    <= shift_d;
      serial_out <= serial_d;
      frame_done <= (state == STOP) && bit_tick;
      if (handshake) begin
        size_q   <= clamp_data_size(data_size);
        period_q <= clamp_bit_period(bit_period);
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, back-to-back, busy/clamp, reset mid-frame, parity.
// Parity cases run only when UART_TX_PARITY_EN is defined for the build.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_out;
  logic        tx_busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .data_size  (data_size),
    .bit_period (bit_period),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Starts at a negedge with the transmitter idle; ends at the negedge of the frame_done cycle.
  task automatic run_frame(input logic [7:0] data, input logic [3:0] size, input logic [13:0] period,
                           input int eff_bits, input int eff_period, input logic exp_par,
                           input bit hold, input logic [7:0] next_data, input bit disturb);
    logic [10:0] exp_bits;
    int          nbits;
    int          len;
    nbits = 2 + eff_bits + PAR_BITS;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < eff_bits; k++) exp_bits[1+k] = data[k];
    if (PAR_BITS == 1) exp_bits[1+eff_bits] = exp_par;
    len = nbits * eff_period;

    tx_valid   = 1'b1;
    tx_data    = data;
    data_size  = size;
    bit_period = period;
    check("ready_before_frame", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (hold) tx_data = next_data;
    else      tx_valid = 1'b0;

    for (int i = 0; i < len; i++) begin
      check("serial_out", serial_out, exp_bits[i/eff_period]);
      check("busy_in_frame", tx_busy, 1);
      check("ready_low_in_frame", tx_ready, 0);
      check("done_low_in_frame", frame_done, 0);
      if (disturb && i == len/2) begin
        tx_valid   = 1'b1;
        tx_data    = ~data;
        data_size  = 4'd5;
        bit_period = 14'd3;
      end
      if (disturb && i == len/2 + 1) tx_valid = 1'b0;
      @(negedge clk);
    end

    check("done_pulse", frame_done, 1);
    check("ready_at_done", tx_ready, 1);
    check("line_high_at_done", serial_out, 1);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_line", serial_out, 1);
      check("idle_busy", tx_busy, 0);
      check("idle_done", frame_done, 0);
    end
  endtask

  initial begin
    n_rst      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    data_size  = 4'd8;
    bit_period = 14'd10;
    #1 n_rst = 1'b0;
    #1;
    check("rst_serial_out", serial_out, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    idle_check(2);

    // Basic: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 at 10 cycles/bit, done after 100 cycles.
    run_frame(8'hA5, 4'd8, 14'd10, 8, 10, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(3);

    // Short character: 5 ones only, 28-cycle frame.
    run_frame(8'hFF, 4'd5, 14'd4, 5, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_check(3);

    // Back-to-back with tx_valid held: 0x00 then 0xFF, ready high only in the done cycle.
    run_frame(8'h00, 4'd8, 14'd3, 8, 3, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_frame(8'hFF, 4'd8, 14'd3, 8, 3, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(3);

    // Busy: mid-frame input changes and a tx_valid pulse are ignored.
    run_frame(8'h5A, 4'd8, 14'd6, 8, 6, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_check(5);

    // Clamp: size 12 sends 8 bits; period 0 gives 1-cycle bits.
    run_frame(8'h81, 4'd12, 14'd5, 8, 5, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(2);
    run_frame(8'hC3, 4'd6, 14'd0, 6, 1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(2);

    // Reset during data bit 3 of 0xA5 (line low there), then a clean 0x3C frame.
    tx_valid   = 1'b1;
    tx_data    = 8'hA5;
    data_size  = 4'd8;
    bit_period = 14'd10;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (44) @(negedge clk);
    check("bit3_before_reset", serial_out, 0);
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_serial_out", serial_out, 1);
    check("rst_mid_tx_ready", tx_ready, 1);
    check("rst_mid_tx_busy", tx_busy, 0);
    check("rst_mid_frame_done", frame_done, 0);
    @(negedge clk);
    check("rst_hold_frame_done", frame_done, 0);
    n_rst = 1'b1;
    idle_check(3);
    run_frame(8'h3C, 4'd8, 14'd10, 8, 10, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(2);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 in 7 bits -> parity 1, 0x03 -> parity 0, both 10 bit periods.
    run_frame(8'h07, 4'd7, 14'd4, 7, 4, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_check(2);
    run_frame(8'h03, 4'd7, 14'd4, 7, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_check(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
